// File: rtl/fft_pkg.sv
// Shared FFT helpers: size derivation, twiddle packing and rounding.
// Used by the twiddle ROM and the parallel twiddle sequencer.
package fft_pkg;

    localparam real PI = 3.14159265358979323846;

    function automatic int clog2(input int v);
        return $clog2(v);
    endfunction

    // Stage select width: enough bits for 0..LOG2N-1, never zero.
    function automatic int sw_of(input int log2n);
        return (log2n > 1) ? clog2(log2n) : 1;
    endfunction

    function automatic int steps_of(input int n, input int lanes);
        return n / (2 * lanes);
    endfunction

    // MSB of lane l in the output bus; lane 0 occupies the top slice.
    function automatic int lane_msb(input int l, input int lanes,
                                    input int nbits);
        return lanes * 2 * nbits - 1 - l * 2 * nbits;
    endfunction

    // MSB of ROM entry k; entry 0 occupies the top slice.
    function automatic int entry_msb(input int k, input int n,
                                     input int nbits);
        return (n / 2) * 2 * nbits - 1 - k * 2 * nbits;
    endfunction

    // Real (im=0) or imaginary (im=1) part of W_N^k = exp(-j*2*pi*k/N),
    // scaled to full positive range and rounded half away from zero.
    function automatic int tw_part(input int k, input int n,
                                   input int nbits, input bit im);
        real ang;
        real scl;
        real v;
        ang = 2.0 * PI * real'(k) / real'(n);
        scl = (2.0 ** (nbits - 1)) - 1.0;
        v   = im ? -$sin(ang) * scl : $cos(ang) * scl;
        return $rtoi((v < 0.0) ? v - 0.5 : v + 0.5);
    endfunction

endpackage

// File: rtl/twiddle_rom.sv
// Constant twiddle table: N/2 entries of {re,im}, entry 0 in the MSBs.
// Ports: rom - packed table output (purely combinational constant).
module twiddle_rom
    import fft_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int N     = 128
) (
    output logic [N*NBITS-1:0] rom
);

    for (genvar k = 0; k < N / 2; k++) begin : g_ent
        assign rom[entry_msb(k, N, NBITS) -: 2*NBITS] =
            {NBITS'(tw_part(k, N, NBITS, 1'b0)),
             NBITS'(tw_part(k, N, NBITS, 1'b1))};
    end

endmodule

// File: rtl/twiddle_seq_par.sv
// Parallel twiddle sequencer: LANES coefficients W_N^k per enabled cycle,
// address stride 2^stage, frame-aligned by sync.
// Ports: clk, rst (sync, active-high), en (advance), sync (restart, latch
// stage), stage (stride select), coeff_out (lane0 in MSBs, {re,im}),
// valid (output updated), last (final group of the frame).
module twiddle_seq_par
    import fft_pkg::*;
#(
    parameter int NBITS = 16,
    parameter int N     = 128,
    parameter int LANES = 4,
    localparam int LOG2N = clog2(N),
    localparam int SW    = sw_of(LOG2N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     sync,
    input  logic [SW-1:0]            stage,
    output logic [LANES*2*NBITS-1:0] coeff_out,
    output logic                     valid,
    output logic                     last
);

    localparam int STEPS = steps_of(N, LANES);
    localparam int IW    = (STEPS > 1) ? clog2(STEPS) : 1;
    localparam int AW    = LOG2N - 1;
    localparam int CW    = 2 * NBITS;

    logic [N*NBITS-1:0]     rom;
    logic [CW-1:0]          ent [N/2];
    logic [IW-1:0]          index;
    logic [IW-1:0]          grp;
    logic [SW-1:0]          stage_q;
    logic [SW-1:0]          stage_sat;
    logic [SW-1:0]          sel_stage;
    logic [LANES*CW-1:0]    coeff_next;
    logic                   grp_last;

    twiddle_rom #(.NBITS(NBITS), .N(N)) u_rom (.rom(rom));

    for (genvar k = 0; k < N / 2; k++) begin : g_split
        assign ent[k] = rom[entry_msb(k, N, NBITS) -: CW];
    end

    assign stage_sat = (int'(stage) >= LOG2N) ? SW'(LOG2N - 1) : stage;

    // A sync cycle restarts at group 0 using the freshly latched stride.
    assign sel_stage = sync ? stage_sat : stage_q;
    assign grp       = sync ? '0 : index;
    assign grp_last  = (grp == IW'(STEPS - 1));

    // Linear index is formed LOG2N bits wide, shifted, then truncated
    // to the table range, which realises the mod N/2 wrap.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [LOG2N-1:0] lin;
        logic [AW-1:0]    addr;
        assign lin  = LOG2N'(grp) * LOG2N'(LANES) + LOG2N'(l);
        assign addr = AW'(lin << sel_stage);
        assign coeff_next[lane_msb(l, LANES, NBITS) -: CW] = ent[addr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            coeff_out <= '0;
            valid     <= 1'b0;
            last      <= 1'b0;
            index     <= '0;
            stage_q   <= '0;
        end else begin
            valid <= 1'b0;
            last  <= 1'b0;
            if (sync) begin
                stage_q <= stage_sat;
            end
            if (en) begin
                coeff_out <= coeff_next;
                valid     <= 1'b1;
                last      <= grp_last;
                index     <= grp_last ? '0 : grp + 1'b1;
            end else if (sync) begin
                index <= '0;
            end
        end
    end

endmodule

// File: tb/tb_twiddle_seq_par.sv
// Self-checking bench for twiddle_seq_par over four size/lane configs.
// Table vectors, directed corner sequences and a random reference run.
module tb_twiddle_seq_par;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [2:0] stg = 3'd0;

    logic [31:0]  coa;
    logic [63:0]  cob;
    logic [31:0]  coc;
    logic [127:0] cod;
    logic [3:0]   vld;
    logic [3:0]   lst;
    logic [127:0] act [4];

    always #5 clk = ~clk;

    twiddle_seq_par #(.NBITS(16), .N(8), .LANES(1)) u_a (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .stage(stg[1:0]),
        .coeff_out(coa), .valid(vld[0]), .last(lst[0]));
    twiddle_seq_par #(.NBITS(16), .N(8), .LANES(2)) u_b (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .stage(stg[1:0]),
        .coeff_out(cob), .valid(vld[1]), .last(lst[1]));
    twiddle_seq_par #(.NBITS(16), .N(16), .LANES(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .stage(stg[1:0]),
        .coeff_out(coc), .valid(vld[2]), .last(lst[2]));
    twiddle_seq_par #(.NBITS(16), .N(128), .LANES(4)) u_d (
        .clk(clk), .rst(rst), .en(en), .sync(sync), .stage(stg),
        .coeff_out(cod), .valid(vld[3]), .last(lst[3]));

    assign act[0] = {96'b0, coa};
    assign act[1] = {64'b0, cob};
    assign act[2] = {96'b0, coc};
    assign act[3] = cod;

    int errors = 0;
    int checks = 0;

    // Reference state: frame position, latched stride and expected outputs.
    int           mn [4] = '{8, 8, 16, 128};
    int           ml [4] = '{1, 2, 1, 4};
    int           msw[4] = '{2, 2, 2, 3};
    int           mpos[4];
    int           mst [4];
    logic [127:0] mexp[4];
    logic         mv  [4];
    logic         mlast[4];

    function automatic int rnd(input real v);
        return (v < 0.0) ? -$rtoi($floor(-v + 0.5)) : $rtoi($floor(v + 0.5));
    endfunction

    function automatic logic [31:0] gold(input int k, input int n);
        real a;
        int  re;
        int  im;
        logic [15:0] r16;
        logic [15:0] i16;
        a   = 2.0 * $acos(-1.0) * real'(k) / real'(n);
        re  = rnd($cos(a) * 32767.0);
        im  = rnd(-$sin(a) * 32767.0);
        r16 = re[15:0];
        i16 = im[15:0];
        return {r16, i16};
    endfunction

    task automatic model(input logic e, input logic s, input logic r,
                         input logic [2:0] st_in);
        for (int d = 0; d < 4; d++) begin
            int log2n;
            int steps;
            int g;
            int sv;
            log2n = $clog2(mn[d]);
            steps = mn[d] / (2 * ml[d]);
            if (r) begin
                mexp[d] = '0; mv[d] = 0; mlast[d] = 0;
                mpos[d] = 0;  mst[d] = 0;
            end else begin
                if (s) begin
                    sv = int'(st_in) % (1 << msw[d]);
                    mst[d] = (sv >= log2n) ? log2n - 1 : sv;
                    if (!e) mpos[d] = 0;
                end
                if (e) begin
                    g = s ? 0 : mpos[d];
                    mexp[d] = '0;
                    for (int l = 0; l < ml[d]; l++) begin
                        int k;
                        k = ((g * ml[d] + l) * (1 << mst[d])) % (mn[d] / 2);
                        mexp[d][(ml[d]-1-l)*32 +: 32] = gold(k, mn[d]);
                    end
                    mv[d] = 1;
                    mlast[d] = (g == steps - 1);
                    mpos[d] = (g + 1) % steps;
                end else begin
                    mv[d] = 0;
                    mlast[d] = 0;
                end
            end
        end
    endtask

    task automatic step(input logic e, input logic s, input logic r,
                        input logic [2:0] st_in);
        en = e; sync = s; rst = r; stg = st_in;
        @(posedge clk);
        #1;
        model(e, s, r, st_in);
        for (int d = 0; d < 4; d++) begin
            checks++;
            if (act[d] !== mexp[d]) begin
                errors++;
                $display("FAIL dut%0d coeff got %h want %h", d, act[d], mexp[d]);
            end
            checks++;
            if (vld[d] !== mv[d]) begin
                errors++;
                $display("FAIL dut%0d valid got %b want %b", d, vld[d], mv[d]);
            end
            checks++;
            if (lst[d] !== mlast[d]) begin
                errors++;
                $display("FAIL dut%0d last got %b want %b", d, lst[d], mlast[d]);
            end
        end
    endtask

    typedef struct {
        logic       e;
        logic       s;
        logic       r;
        logic [2:0] st;
        logic       ev;
        logic       el;
        int         ek;
    } vec_t;

    initial begin
        vec_t tbl[15];
        logic [31:0] want;
        // N=8, LANES=1: free-running wrap, then en gaps that must hold.
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, -1};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 0};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 0};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 2};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b1, 3};

        for (int d = 0; d < 4; d++) begin
            mpos[d] = 0; mst[d] = 0; mexp[d] = '0; mv[d] = 0; mlast[d] = 0;
        end

        for (int i = 0; i < 15; i++) begin
            step(tbl[i].e, tbl[i].s, tbl[i].r, tbl[i].st);
            want = (tbl[i].ek < 0) ? 32'd0 : gold(tbl[i].ek, 8);
            checks++;
            if (coa !== want || vld[0] !== tbl[i].ev || lst[0] !== tbl[i].el) begin
                errors++;
                $display("FAIL tbl%0d got %h/%b/%b want %h/%b/%b", i,
                         coa, vld[0], lst[0], want, tbl[i].ev, tbl[i].el);
            end
        end

        // Stride sweep via sync, including saturation of an oversized stage.
        for (int s = 0; s < 4; s++) begin
            logic [2:0] sv;
            sv = (s == 3) ? 3'd7 : 3'(s);
            step(1'b1, 1'b1, 1'b0, sv);
            for (int j = 0; j < 4; j++) step(1'b1, 1'b0, 1'b0, 3'd1);
        end
        checks++;
        if (cob !== {gold(0, 8), gold(0, 8)}) begin
            errors++;
            $display("FAIL sat_b got %h want %h", cob, {gold(0, 8), gold(0, 8)});
        end

        // Mid-frame sync with and without en.
        step(1'b1, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b1, 1'b1, 1'b0, 3'd0);
        checks++;
        if (coc !== gold(0, 16)) begin
            errors++;
            $display("FAIL resync_c got %h want %h", coc, gold(0, 16));
        end
        step(1'b1, 1'b0, 1'b0, 3'd0);
        step(1'b0, 1'b1, 1'b0, 3'd0);
        step(1'b1, 1'b0, 1'b0, 3'd0);

        // Reset mid-frame at a nonzero stride returns to stage 0.
        step(1'b1, 1'b1, 1'b0, 3'd1);
        step(1'b1, 1'b0, 1'b0, 3'd1);
        step(1'b1, 1'b0, 1'b1, 3'd1);
        step(1'b1, 1'b0, 1'b0, 3'd1);
        step(1'b1, 1'b0, 1'b0, 3'd1);
        checks++;
        if (coa !== gold(1, 8)) begin
            errors++;
            $display("FAIL rst_stage got %h want %h", coa, gold(1, 8));
        end

        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0),
                 1'($urandom_range(0, 39) == 0),
                 3'($urandom_range(0, 7)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
